// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - 5-stage pipeline hazard unit with forwarding, lw/branch stalls and multi-cycle E tracker
// Optional feature macro: HAZARD_STALL_CNT_EN (adds the saturating stall_cycles counter output).
module hazard_unit_mc #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          regwriteE,
    input  logic          regwriteM,
    input  logic          regwriteW,
    input  logic          memtoregE,
    input  logic          memtoregM,
    input  logic          branchD,
    input  logic          md_startE,
    input  logic [AW-1:0] writeregE,
    input  logic [AW-1:0] writeregM,
    input  logic [AW-1:0] writeregW,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rtE,
    output logic [1:0]    forwardAE,
    output logic [1:0]    forwardBE,
    output logic          forwardAD,
    output logic          forwardBD,
    output logic          stallF,
    output logic          stallD,
    output logic          stallE,
    output logic          flushE,
    output logic          flushM,
    output logic          md_busy,
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0]   stall_cycles,
`endif
    output logic          md_done
);

    // Latency counter width is derived from MD_LAT and deliberately not a port parameter.
    localparam int            CW      = $clog2(MD_LAT + 1);
    localparam logic [CW-1:0] LAT_M1  = CW'(MD_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] REG_0   = '0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    md_state_t     r_state;
    md_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_mdstall;
    logic          w_md_done;
    logic          w_lwstall;
    logic          w_branchstall;
    logic          w_stall_fd;

    // Operand forwarding for E: M result has priority over W; register 0 never forwards.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (rsE != REG_0 && rsE == writeregM && regwriteM) begin
            forwardAE = 2'b10;
        end else if (rsE != REG_0 && rsE == writeregW && regwriteW) begin
            forwardAE = 2'b01;
        end
        if (rtE != REG_0 && rtE == writeregM && regwriteM) begin
            forwardBE = 2'b10;
        end else if (rtE != REG_0 && rtE == writeregW && regwriteW) begin
            forwardBE = 2'b01;
        end
    end

    // Branch comparator in D may only take the M-stage result.
    always_comb begin
        forwardAD = (rsD != REG_0) && (rsD == writeregM) && regwriteM;
        forwardBD = (rtD != REG_0) && (rtD == writeregM) && regwriteM;
    end

    // Load-use and branch-compare stall terms; a write to register 0 never creates a dependency.
    always_comb begin
        w_lwstall = memtoregE && (writeregE != REG_0)
                    && ((rsD == writeregE) || (rtD == writeregE));
        w_branchstall = branchD
                        && ((regwriteE && (writeregE != REG_0)
                             && ((writeregE == rsD) || (writeregE == rtD)))
                            || (memtoregM && (writeregM != REG_0)
                             && ((writeregM == rsD) || (writeregM == rtD))));
    end

    // Multi-cycle tracker next state and stall/done; reset masks both outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mdstall   = 1'b0;
        w_md_done   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (md_startE) begin
                        if (MD_LAT == 1) begin
                            w_md_done = 1'b1;
                        end else begin
                            w_mdstall   = 1'b1;
                            w_cnt_nxt   = LAT_M1;
                            w_state_nxt = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt > CNT_ONE) begin
                        w_mdstall = 1'b1;
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else begin
                        w_md_done   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Tracker state register; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pipeline control: a held E stage must not be flushed, so mdstall wins over flushE.
    always_comb begin
        w_stall_fd = w_lwstall | w_branchstall | w_mdstall;
        stallF     = w_stall_fd;
        stallD     = w_stall_fd;
        stallE     = w_mdstall;
        flushM     = w_mdstall;
        flushE     = (w_lwstall | w_branchstall) & ~w_mdstall;
        md_busy    = (r_state == S_BUSY);
        md_done    = w_md_done;
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of cycles in which the front end was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall_fd && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - self-checking bench for hazard_unit_mc (MD_LAT=4 and MD_LAT=1 instances)
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, md_startE;
    logic [4:0] writeregE, writeregM, writeregW, rsD, rtD, rsE, rtE;

    logic [1:0] fAE [2];
    logic [1:0] fBE [2];
    logic       fAD [2];
    logic       fBD [2];
    logic       sF [2];
    logic       sD [2];
    logic       sE [2];
    logic       flE [2];
    logic       flM [2];
    logic       busy [2];
    logic       done [2];
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] scyc [2];
`endif

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Model state: age of the op occupying E (cycles already spent), -1 when none.
    int          age [2] = '{-1, -1};
    logic [31:0] scnt [2] = '{32'd0, 32'd0};

    always #5 clk = ~clk;

    hazard_unit_mc #(.AW(5), .MD_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .md_startE(md_startE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .forwardAE(fAE[0]), .forwardBE(fBE[0]), .forwardAD(fAD[0]), .forwardBD(fBD[0]),
        .stallF(sF[0]), .stallD(sD[0]), .stallE(sE[0]), .flushE(flE[0]), .flushM(flM[0]),
        .md_busy(busy[0]),
`ifdef HAZARD_STALL_CNT_EN
        .stall_cycles(scyc[0]),
`endif
        .md_done(done[0])
    );

    hazard_unit_mc #(.AW(5), .MD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .md_startE(md_startE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .forwardAE(fAE[1]), .forwardBE(fBE[1]), .forwardAD(fAD[1]), .forwardBD(fBD[1]),
        .stallF(sF[1]), .stallD(sD[1]), .stallE(sE[1]), .flushE(flE[1]), .flushM(flM[1]),
        .md_busy(busy[1]),
`ifdef HAZARD_STALL_CNT_EN
        .stall_cycles(scyc[1]),
`endif
        .md_done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] r);
        if (r != 5'd0 && r == writeregM && regwriteM) return 2'b10;
        if (r != 5'd0 && r == writeregW && regwriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit lw_exp();
        return memtoregE && writeregE != 5'd0 && (rsD == writeregE || rtD == writeregE);
    endfunction

    function automatic bit br_exp();
        return branchD && ((regwriteE && writeregE != 5'd0 && (writeregE == rsD || writeregE == rtD))
                        || (memtoregM && writeregM != 5'd0 && (writeregM == rsD || writeregM == rtD)));
    endfunction

    // Effective age of the op in E this cycle (a start seen while idle is age 0).
    function automatic int eff_age(input int k);
        if (age[k] >= 0) return age[k];
        return md_startE ? 0 : -1;
    endfunction

    function automatic bit mds_exp(input int k);
        int ea;
        ea = eff_age(k);
        return !rst && ea >= 0 && ea < lat_of(k) - 1;
    endfunction

    function automatic bit done_exp(input int k);
        return !rst && eff_age(k) == lat_of(k) - 1;
    endfunction

    // Advance the model at each clock edge using the inputs present before the edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  ea;
            bit  sf;
            ea = eff_age(k);
            sf = lw_exp() | br_exp() | mds_exp(k);
            if (rst) begin
                age[k]  = -1;
                scnt[k] = 32'd0;
            end else begin
                age[k] = (ea >= 0 && ea < lat_of(k) - 1) ? ea + 1 : -1;
                if (sf && scnt[k] != 32'hFFFF_FFFF) scnt[k] = scnt[k] + 32'd1;
            end
        end
    end

    // Compare every output of both instances against the model mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                bit lw, br, md;
                lw = lw_exp();
                br = br_exp();
                md = mds_exp(k);
                chk($sformatf("u%0d_forwardAE", k), fAE[k], fwd_exp(rsE));
                chk($sformatf("u%0d_forwardBE", k), fBE[k], fwd_exp(rtE));
                chk($sformatf("u%0d_forwardAD", k), fAD[k], rsD != 0 && rsD == writeregM && regwriteM);
                chk($sformatf("u%0d_forwardBD", k), fBD[k], rtD != 0 && rtD == writeregM && regwriteM);
                chk($sformatf("u%0d_stallF", k), sF[k], lw | br | md);
                chk($sformatf("u%0d_stallD", k), sD[k], lw | br | md);
                chk($sformatf("u%0d_stallE", k), sE[k], md);
                chk($sformatf("u%0d_flushM", k), flM[k], md);
                chk($sformatf("u%0d_flushE", k), flE[k], (lw | br) & ~md);
                chk($sformatf("u%0d_md_busy", k), busy[k], age[k] >= 1);
                chk($sformatf("u%0d_md_done", k), done[k], done_exp(k));
`ifdef HAZARD_STALL_CNT_EN
                chk($sformatf("u%0d_stall_cycles", k), scyc[k], scnt[k]);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
        branchD = 0; md_startE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    endtask

    initial begin
        int  n_stall;
        int  done_at;
        logic [7:0] pat;

        clr();
        rst = 1;
        tick();
        mon_en = 1;
        tick();
        #1;
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_stallE", sE[0], 0);
        chk("rst_flushM", flM[0], 0);
        tick();
        rst = 0;
        #1;
        chk("post_rst_busy", busy[0], 0);

        // Forwarding priority
        tick();
        rsE = 5; rtE = 5; writeregM = 5; writeregW = 5; regwriteM = 1; regwriteW = 1;
        #1;
        chk("fwd_m_AE", fAE[0], 2'b10);
        chk("fwd_m_BE", fBE[0], 2'b10);
        tick();
        regwriteM = 0;
        #1;
        chk("fwd_w_AE", fAE[0], 2'b01);
        chk("fwd_w_BE", fBE[0], 2'b01);
        tick();
        rsE = 0;
        #1;
        chk("fwd_r0_AE", fAE[0], 2'b00);
        chk("fwd_r0_BE", fBE[0], 2'b01);

        // Load-use
        tick();
        clr(); memtoregE = 1; writeregE = 8; rtD = 8;
        #1;
        chk("lw_stallF", sF[0], 1);
        chk("lw_stallD", sD[0], 1);
        chk("lw_flushE", flE[0], 1);
        chk("lw_stallE", sE[0], 0);
        tick();
        writeregE = 0;
        #1;
        chk("lw_r0_stallF", sF[0], 0);
        chk("lw_r0_flushE", flE[0], 0);

        // Branch compare stall then forward from M
        tick();
        clr(); branchD = 1; regwriteE = 1; writeregE = 3; rsD = 3;
        #1;
        chk("br_stallF", sF[0], 1);
        chk("br_flushE", flE[0], 1);
        tick();
        regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 3; memtoregM = 0;
        #1;
        chk("br_fwd_stallF", sF[0], 0);
        chk("br_fwd_AD", fAD[0], 1);

        // Multi-cycle op, with a coincident load-use during BUSY
        tick();
        clr(); md_startE = 1;
        #1;
        chk("md_c1_stallF", sF[0], 1);
        chk("md_c1_stallE", sE[0], 1);
        chk("md_c1_flushM", flM[0], 1);
        chk("md_c1_busy", busy[0], 0);
        chk("md1_c1_done", done[1], 1);
        chk("md1_c1_stallF", sF[1], 0);
        tick();
        md_startE = 0; memtoregE = 1; writeregE = 8; rtD = 8;
        #1;
        chk("md_c2_busy", busy[0], 1);
        chk("md_c2_stallE", sE[0], 1);
        chk("md_c2_flushE", flE[0], 0);
        chk("md1_c2_flushE", flE[1], 1);
        tick();
        clr();
        #1;
        chk("md_c3_busy", busy[0], 1);
        chk("md_c3_stallE", sE[0], 1);
        tick();
        #1;
        chk("md_c4_done", done[0], 1);
        chk("md_c4_stallF", sF[0], 0);
        chk("md_c4_stallE", sE[0], 0);
        chk("md_c4_flushM", flM[0], 0);
        tick();
        #1;
        chk("md_c5_busy", busy[0], 0);
        chk("md_c5_done", done[0], 0);

        // Reset in the middle of an op, then a full restart
        tick();
        md_startE = 1;
        tick();
        md_startE = 0; rst = 1;
        #1;
        chk("abort_stallE", sE[0], 0);
        chk("abort_done", done[0], 0);
        tick();
        rst = 0;
        #1;
        chk("abort_busy", busy[0], 0);
        chk("abort_stallF", sF[0], 0);
        n_stall = 0;
        done_at = -1;
        tick();
        md_startE = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (sE[0]) n_stall++;
            if (done[0] && done_at < 0) done_at = i;
            tick();
            md_startE = 0;
        end
        chk("restart_stall_cycles", n_stall, 3);
        chk("restart_done_at", done_at, 3);

        // Back-to-back ops with md_startE held high
        tick();
        md_startE = 1;
        pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            #1;
            pat = {pat[6:0], sE[0]};
            tick();
        end
        md_startE = 0;
        chk("b2b_stall_pattern", pat, 8'b1110_1110);

        // Mixed vectors checked by the model only
        for (int i = 0; i < 80; i++) begin
            tick();
            rst       = ($urandom_range(0, 19) == 0);
            regwriteE = $urandom_range(0, 1); regwriteM = $urandom_range(0, 1);
            regwriteW = $urandom_range(0, 1); memtoregE = $urandom_range(0, 1);
            memtoregM = $urandom_range(0, 1); branchD   = $urandom_range(0, 1);
            md_startE = ($urandom_range(0, 3) == 0);
            writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3)); rsD = 5'($urandom_range(0, 3));
            rtD = 5'($urandom_range(0, 3)); rsE = 5'($urandom_range(0, 3));
            rtE = 5'($urandom_range(0, 3));
        end

`ifdef HAZARD_STALL_CNT_EN
        // Stall counter: five load-use cycles after reset
        tick();
        clr(); rst = 1;
        tick();
        rst = 0; memtoregE = 1; writeregE = 8; rtD = 8;
        for (int i = 0; i < 4; i++) tick();
        tick();
        clr();
        #1;
        chk("stall_cycles_5", scyc[1], 32'd5);
`endif

        tick();
        clr(); rst = 0;
        tick();
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised hazard unit for the 5-stage MIPS pipeline.
- Keeps the existing E/D forwarding, load-use stall and branch-compare stall.
- Excludes register 0 from every stall check.
- Adds a sequential tracker for a multi-cycle execute unit (mult/div), which freezes F/D/E and bubbles M while the operation occupies E.
- Sits beside the datapath and drives all pipeline-register enable and flush lines.

Parameters:
AW, 5, register-address width of all write-reg/source fields.
MD_LAT, 4, total cycles a multi-cycle op occupies E (legal range 1..255).
CW, $clog2(MD_LAT+1), latency counter width. Local; not overridable.

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous active-high reset
regwriteE/regwriteM/regwriteW  input  1 each  stage writes register file
memtoregE/memtoregM  input  1 each  stage is a load
branchD  input  1  branch compares in D
md_startE  input  1  instruction in E is a multi-cycle op
writeregE/writeregM/writeregW  input  AW each  destination register
rsD/rtD/rsE/rtE  input  AW each  source registers
forwardAE/forwardBE  output  2 each  ALU operand select: 10=M, 01=W, 00=RF
forwardAD/forwardBD  output  1 each  branch comparator takes M result
stallF/stallD/stallE  output  1 each  hold stage register
flushE/flushM  output  1 each  insert bubble into E / M
md_busy  output  1  FSM not IDLE
md_done  output  1  multi-cycle op completes this cycle

Behaviour:
Everything is clocked on the rising edge of clk. Reset is synchronous and active-high; no other reset path exists.

Forwarding (combinational):
- forwardAE = 10 if rsE!=0, rsE==writeregM and regwriteM.
- Otherwise forwardAE = 01 if rsE!=0, rsE==writeregW and regwriteW.
- Otherwise forwardAE = 00.
- forwardBE uses the same rules on rtE.
- forwardAD = rsD!=0 && rsD==writeregM && regwriteM; forwardBD is the same on rtD.

Stall terms:
- lwstall = memtoregE && writeregE!=0 && (rsD==writeregE || rtD==writeregE).
- branchstall = branchD && [ (regwriteE && writeregE!=0 && writeregE in {rsD,rtD}) || (memtoregM && writeregM!=0 && writeregM in {rsD,rtD}) ].

Multi-cycle FSM:
- State register holds IDLE or BUSY; cnt is CW bits.
- Reset: state=IDLE, cnt=0, md_busy=0, md_done=0.
- IDLE with md_startE=1:
  - MD_LAT==1: md_done=1 and mdstall=0; state stays IDLE.
  - MD_LAT>1: mdstall=1, cnt<=MD_LAT-1, state<=BUSY.
- BUSY, cnt>1: mdstall=1, cnt<=cnt-1.
- BUSY, cnt==1: md_done=1, mdstall=0, state<=IDLE, cnt<=0.
- Net effect: the op spends exactly MD_LAT cycles in E, with MD_LAT-1 stall cycles.
- md_startE is ignored while in BUSY. It is level-sampled only in IDLE.
- Back-to-back ops: a new md_startE seen in IDLE on the cycle after md_done starts a fresh sequence with no gap.

Outputs:
- stallF = stallD = lwstall | branchstall | mdstall.
- stallE = mdstall.
- flushM = mdstall.
- flushE = (lwstall | branchstall) & ~mdstall. While E is held, a flush would destroy the multi-cycle op, so mdstall has priority.
- md_busy = (state==BUSY).

Reset behaviour:
- While rst=1, mdstall, md_done, stallE and flushM are forced to 0.
- Forwarding and the lw/branch terms stay purely combinational during reset.
- Reset asserted mid-BUSY aborts the op: the next cycle is IDLE with cnt=0.

Optional Feature:
HAZARD_STALL_CNT_EN.
- Defined: adds output stall_cycles [31:0].
  - Increments by 1 every cycle stallF=1.
  - Cleared by rst.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Forwarding priority: rsE=rtE=5, writeregM=writeregW=5, regwriteM=regwriteW=1 -> forwardAE=forwardBE=10. Clear regwriteM -> both 01. Set rsE=0 -> forwardAE=00.
- Load-use: memtoregE=1, writeregE=8, rtD=8 -> stallF=stallD=flushE=1, stallE=0. Set writeregE=0 -> all 0.
- Branch stall: branchD=1, regwriteE=1, writeregE=3, rsD=3 -> stall and flushE. Next cycle, regwriteM=1, writeregM=3, memtoregM=0 -> no stall, forwardAD=1.
- Multi-cycle, MD_LAT=4: pulse md_startE -> stallF/D/E=flushM=1 for exactly 3 cycles with md_busy=1 on cycles 2-3. md_done=1 on cycle 4 with all stalls 0. A coincident lwstall during BUSY gives flushE=0.
- Reset mid-op: rst=1 on BUSY cycle 2 -> next cycle state IDLE, md_busy=0, stalls 0. A new md_startE restarts a full 4-cycle sequence.
- MD_LAT=1 build, with HAZARD_STALL_CNT_EN defined: md_startE -> md_done=1 the same cycle with no stall. Then 5 load-use cycles -> stall_cycles=5.
